vector_reg_file: RTL

VECTOR_REG_FILE -- requirements
Module: vector_reg_file

---
 rtl/vrf_pkg.sv | 28 ++
 rtl/vrf_xfer_ctrl.sv | 180 ++++++++++++++++++
 rtl/vector_reg_file.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vrf_pkg.sv
// vrf_pkg -- shared definitions for the vector register file.
//   * default parameter values for vector_reg_file / vrf_xfer_ctrl
//   * transfer FSM state encoding
//   * LFSR seed/polynomial and single-step helper, used only when the
//     design is built with VRF_LFSR_FILL_EN defined
package vrf_pkg;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_VLEN     = 512;
  localparam int DEF_ELEM_W   = 32;
  localparam int DEF_BEAT_W   = 128;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

endpackage

// File: rtl/vrf_xfer_ctrl.sv
// vrf_xfer_ctrl -- memory-transfer engine for the vector register file.
// Owns the transfer FSM (IDLE/LOAD/STORE/DONE), the beat counter and the
// VLEN-bit shadow buffer. Loads assemble beats in the shadow and hand a
// single commit to the top on the final handshake; stores snapshot the
// target register at start and stream it out beat by beat.
// Optional: VRF_LFSR_FILL_EN adds fill_en, which runs a LOAD whose beats
// come from a 32-bit Galois LFSR instead of ld_beat.
// Ports:
//   clk, reset          clock (rising), async active-low reset
//   ld_start, st_start  transfer requests (honoured in IDLE only)
//   fill_en             LFSR fill request (VRF_LFSR_FILL_EN only)
//   xfer_reg            target register, latched at start
//   snap_data           current contents of regs[xfer_reg] from the top
//   ld_valid/ld_ready/ld_beat   load beat handshake
//   st_valid/st_ready/st_beat   store beat handshake
//   xfer_busy, xfer_done        status / completion pulse
//   load_active, tgt_reg        conflict-detection info for the top
//   commit_en, commit_data      atomic register commit on final load beat
module vrf_xfer_ctrl
  import vrf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int VLEN     = DEF_VLEN,
  parameter int BEAT_W   = DEF_BEAT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_start,
  input  logic                        st_start,
`ifdef VRF_LFSR_FILL_EN
  input  logic                        fill_en,
`endif
  input  logic [$clog2(NUM_REGS)-1:0] xfer_reg,
  input  logic [VLEN-1:0]             snap_data,
  input  logic                        ld_valid,
  input  logic [BEAT_W-1:0]           ld_beat,
  output logic                        ld_ready,
  input  logic                        st_ready,
  output logic                        st_valid,
  output logic [BEAT_W-1:0]           st_beat,
  output logic                        xfer_busy,
  output logic                        xfer_done,
  output logic                        load_active,
  output logic [$clog2(NUM_REGS)-1:0] tgt_reg,
  output logic                        commit_en,
  output logic [VLEN-1:0]             commit_data
);

  localparam int NB = VLEN / BEAT_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  xfer_state_t       state;
  logic [CW-1:0]     beat_cnt;
  logic [VLEN-1:0]   shadow;
  logic              load_hs;
  logic              last_beat;
  logic [BEAT_W-1:0] load_beat;

`ifdef VRF_LFSR_FILL_EN
  localparam int WPB = BEAT_W / 32;

  logic              fill_mode;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_walk;
  logic [BEAT_W-1:0] fill_beat;

  // One fill beat packs WPB consecutive LFSR words, lowest word first.
  always_comb begin
    fill_beat = '0;
    lfsr_walk = lfsr;
    for (int w = 0; w < WPB; w++) begin
      fill_beat[w*32 +: 32] = lfsr_walk;
      lfsr_walk             = lfsr_step(lfsr_walk);
    end
  end

  // A fill advances every cycle; it never waits on the external handshake.
  assign load_hs   = (state == LOAD) && (fill_mode || (ld_valid && ld_ready));
  assign load_beat = fill_mode ? fill_beat : ld_beat;
`else
  assign load_hs   = (state == LOAD) && ld_valid && ld_ready;
  assign load_beat = ld_beat;
`endif

  assign last_beat   = (beat_cnt == LAST_BEAT);
  assign load_active = (state == LOAD);
  assign commit_en   = load_hs && last_beat;
  assign st_beat     = st_valid ? shadow[int'(beat_cnt)*BEAT_W +: BEAT_W] : '0;

  // The final beat bypasses the shadow so the commit lands in the same
  // cycle as the last handshake.
  always_comb begin
    commit_data = shadow;
    commit_data[(NB-1)*BEAT_W +: BEAT_W] = load_beat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      shadow    <= '0;
      tgt_reg   <= '0;
      ld_ready  <= 1'b0;
      st_valid  <= 1'b0;
      xfer_busy <= 1'b0;
      xfer_done <= 1'b0;
`ifdef VRF_LFSR_FILL_EN
      fill_mode <= 1'b0;
      lfsr      <= LFSR_SEED;
`endif
    end else begin
      xfer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            state     <= LOAD;
            tgt_reg   <= xfer_reg;
            beat_cnt  <= '0;
            ld_ready  <= 1'b1;
            xfer_busy <= 1'b1;
          end else if (st_start) begin
            state     <= STORE;
            tgt_reg   <= xfer_reg;
            beat_cnt  <= '0;
            shadow    <= snap_data;
            st_valid  <= 1'b1;
            xfer_busy <= 1'b1;
          end
`ifdef VRF_LFSR_FILL_EN
          else if (fill_en) begin
            state     <= LOAD;
            tgt_reg   <= xfer_reg;
            beat_cnt  <= '0;
            fill_mode <= 1'b1;
            xfer_busy <= 1'b1;
          end
`endif
        end
        LOAD: begin
          if (load_hs) begin
            shadow[int'(beat_cnt)*BEAT_W +: BEAT_W] <= load_beat;
`ifdef VRF_LFSR_FILL_EN
            if (fill_mode) lfsr <= lfsr_walk;
`endif
            if (last_beat) begin
              beat_cnt  <= '0;
              state     <= DONE;
              ld_ready  <= 1'b0;
              xfer_done <= 1'b1;
`ifdef VRF_LFSR_FILL_EN
              fill_mode <= 1'b0;
`endif
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        STORE: begin
          if (st_ready) begin
            if (last_beat) begin
              beat_cnt  <= '0;
              state     <= DONE;
              st_valid  <= 1'b0;
              xfer_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          xfer_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vector_reg_file.sv
// vector_reg_file -- NUM_REGS x VLEN vector register file with two
// registered read ports, one element-masked write port and a beat-based
// load/store engine (vrf_xfer_ctrl).
// Optional: VRF_LFSR_FILL_EN adds input fill_en (LFSR fill of xfer_reg).
// Ports:
//   clk, reset                 clock (rising), async active-low reset
//   rd_addr1/2, rd_data1/2     registered reads with write bypass
//   wr_en, wr_addr, wr_data, wr_mask   masked element write
//   wr_conflict                pulses when a write hits the LOAD target
//   ld_start, st_start, xfer_reg, xfer_busy, xfer_done  transfer control
//   ld_valid/ld_ready/ld_beat  load beat stream in
//   st_valid/st_ready/st_beat  store beat stream out
module vector_reg_file
  import vrf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int VLEN     = DEF_VLEN,
  parameter int ELEM_W   = DEF_ELEM_W,
  parameter int BEAT_W   = DEF_BEAT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr1,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr2,
  output logic [VLEN-1:0]             rd_data1,
  output logic [VLEN-1:0]             rd_data2,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [VLEN-1:0]             wr_data,
  input  logic [VLEN/ELEM_W-1:0]      wr_mask,
  output logic                        wr_conflict,
  input  logic                        ld_start,
  input  logic                        st_start,
`ifdef VRF_LFSR_FILL_EN
  input  logic                        fill_en,
`endif
  input  logic [$clog2(NUM_REGS)-1:0] xfer_reg,
  output logic                        xfer_busy,
  output logic                        xfer_done,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [BEAT_W-1:0]           ld_beat,
  output logic                        st_valid,
  input  logic                        st_ready,
  output logic [BEAT_W-1:0]           st_beat
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int NE = VLEN / ELEM_W;

  logic [VLEN-1:0] regs [NUM_REGS];
  logic [VLEN-1:0] lane_bits;
  logic [VLEN-1:0] rd_next1;
  logic [VLEN-1:0] rd_next2;
  logic [VLEN-1:0] commit_data;
  logic [AW-1:0]   tgt_reg;
  logic            load_active;
  logic            commit_en;
  logic            port_we;

  vrf_xfer_ctrl #(
    .NUM_REGS (NUM_REGS),
    .VLEN     (VLEN),
    .BEAT_W   (BEAT_W)
  ) u_xfer (
    .clk         (clk),
    .reset       (reset),
    .ld_start    (ld_start),
    .st_start    (st_start),
`ifdef VRF_LFSR_FILL_EN
    .fill_en     (fill_en),
`endif
    .xfer_reg    (xfer_reg),
    .snap_data   (regs[xfer_reg]),
    .ld_valid    (ld_valid),
    .ld_beat     (ld_beat),
    .ld_ready    (ld_ready),
    .st_ready    (st_ready),
    .st_valid    (st_valid),
    .st_beat     (st_beat),
    .xfer_busy   (xfer_busy),
    .xfer_done   (xfer_done),
    .load_active (load_active),
    .tgt_reg     (tgt_reg),
    .commit_en   (commit_en),
    .commit_data (commit_data)
  );

  // Expand the per-element mask to a per-bit mask.
  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NE; i++) begin
      lane_bits[i*ELEM_W +: ELEM_W] = {ELEM_W{wr_mask[i]}};
    end
  end

  // A port write aimed at the register being loaded is dropped; this also
  // covers the commit cycle, where the load wins.
  assign wr_conflict = load_active && wr_en && (wr_addr == tgt_reg);
  assign port_we     = wr_en && !wr_conflict;

  // Bypass only the lanes the port write actually updates.
  always_comb begin
    rd_next1 = regs[rd_addr1];
    rd_next2 = regs[rd_addr2];
    if (port_we && (wr_addr == rd_addr1)) begin
      rd_next1 = (rd_next1 & ~lane_bits) | (wr_data & lane_bits);
    end
    if (port_we && (wr_addr == rd_addr2)) begin
      rd_next2 = (rd_next2 & ~lane_bits) | (wr_data & lane_bits);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      rd_data1 <= rd_next1;
      rd_data2 <= rd_next2;
    end
  end

  // Storage: masked port writes, then the load commit (later assignment
  // takes precedence, though a collision is already excluded by port_we).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (port_we && (wr_addr == AW'(r))) begin
          regs[r] <= (regs[r] & ~lane_bits) | (wr_data & lane_bits);
        end
        if (commit_en && (tgt_reg == AW'(r))) begin
          regs[r] <= commit_data;
        end
      end
    end
  end

endmodule
